// File: rtl/lemmings_level_sequencer.sv
// ---------------------------------------------------------------------------
// lemmings_level_sequencer
//
// Level-wide controller that sits above the per-lemming walker FSMs.  On a
// start it latches the level configuration, then releases lemmings from the
// hatch one at a time, spaced by a programmable number of idle cycles, until
// the programmed total is out.  Exit and death pulses coming back from the
// walkers update the alive / saved / lost tallies.  Once the hatch is empty
// and nobody is left alive the level is declared done, and win reports
// whether enough lemmings were saved.
//
// Parameters
//   CNT_W         width of total / target / alive / saved / lost / spawn_id
//   INT_W         width of the spawn-interval register and down-timer
//
// Ports
//   clk           clock, all state updates on the rising edge
//   resetn        synchronous active-low reset
//   start         start a level (only accepted in IDLE or DONE)
//   pause         freezes the spawn timer; events are still counted
//   cfg_total     number of lemmings to release, latched on start
//   cfg_target    saved count needed to win, latched on start
//   cfg_interval  idle cycles between releases, latched on start
//   lem_exit      one lemming reached the exit this cycle
//   lem_die       one (different) lemming died this cycle
//   spawn         one-cycle release pulse (combinational)
//   spawn_id      0-based index of the lemming being released, valid with spawn
//   busy          level in progress (SPAWNING, DRAIN, NUKE)
//   alive         lemmings currently in play
//   saved         lemmings saved this level
//   lost          lemmings lost this level
//   done          level finished; held until the next accepted start
//   win           registered saved >= target, valid while done
//   err           sticky event-accounting error, cleared on accepted start
//
// Optional feature (compile-time macro LEMMINGS_NUKE_EN)
//   When defined, adds input nuke and output nuke_all plus a NUKE state.
//   A nuke during a level stops further releases immediately; the level then
//   ends as soon as the remaining lemmings have exited or died.
// ---------------------------------------------------------------------------
module lemmings_level_sequencer #(
    parameter int CNT_W = 8,
    parameter int INT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             pause,
    input  logic [CNT_W-1:0] cfg_total,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [INT_W-1:0] cfg_interval,
    input  logic             lem_exit,
    input  logic             lem_die,
`ifdef LEMMINGS_NUKE_EN
    input  logic             nuke,
    output logic             nuke_all,
`endif
    output logic             spawn,
    output logic [CNT_W-1:0] spawn_id,
    output logic             busy,
    output logic [CNT_W-1:0] alive,
    output logic [CNT_W-1:0] saved,
    output logic [CNT_W-1:0] lost,
    output logic             done,
    output logic             win,
    output logic             err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPAWNING = 3'd1,
        ST_DRAIN    = 3'd2,
`ifdef LEMMINGS_NUKE_EN
        ST_NUKE     = 3'd4,
`endif
        ST_DONE     = 3'd3
    } state_t;

    state_t           state_q, state_d;
    logic [INT_W-1:0] timer_q, timer_d;
    logic [INT_W-1:0] interval_q, interval_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] spawned_q, spawned_d;
    logic [CNT_W-1:0] alive_q, alive_d;
    logic [CNT_W-1:0] saved_q, saved_d;
    logic [CNT_W-1:0] lost_q, lost_d;
    logic             win_q, win_d;
    logic             err_q, err_d;

    logic             in_level;
    logic             last_spawn;
    logic             drained;
    logic [CNT_W-1:0] avail;
    logic [CNT_W-1:0] after_exit;
    logic             exit_ok;
    logic             die_ok;

    // -----------------------------------------------------------------------
    // Shared decode used by both the next-state and datapath logic.
    // The release pulse depends only on registered state and pause, so it is
    // safe to feed it back into the next-state and counter logic.
    // -----------------------------------------------------------------------
    always_comb begin
        in_level   = (state_q == ST_SPAWNING) || (state_q == ST_DRAIN)
`ifdef LEMMINGS_NUKE_EN
                     || (state_q == ST_NUKE)
`endif
                     ;
        spawn      = (state_q == ST_SPAWNING) && (timer_q == '0) && !pause;
        last_spawn = ((spawned_q + CNT_W'(1)) == total_q);
        // Nobody left and nothing in flight this cycle; an out-of-range event
        // with alive==0 keeps us here one more cycle so err is seen in-level.
        drained    = (alive_q == '0) && !lem_exit && !lem_die;

        // Removal accounting: exit takes priority over death when there are
        // not enough lemmings to cover both; anything left over is rejected.
        avail      = alive_q + CNT_W'(spawn);
        exit_ok    = lem_exit && (avail != '0);
        after_exit = avail - CNT_W'(exit_ok);
        die_ok     = lem_die && (after_exit != '0);
    end

    // -----------------------------------------------------------------------
    // State register plus all datapath flops.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            interval_q <= '0;
            total_q    <= '0;
            target_q   <= '0;
            spawned_q  <= '0;
            alive_q    <= '0;
            saved_q    <= '0;
            lost_q     <= '0;
            win_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            interval_q <= interval_d;
            total_q    <= total_d;
            target_q   <= target_d;
            spawned_q  <= spawned_d;
            alive_q    <= alive_d;
            saved_q    <= saved_d;
            lost_q     <= lost_d;
            win_q      <= win_d;
            err_q      <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic.  A start while busy is simply not looked at.
    // A level with zero lemmings goes straight to DRAIN and finishes next
    // cycle with nothing saved.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (cfg_total != '0) ? ST_SPAWNING : ST_DRAIN;
                end
            end
            ST_SPAWNING: begin
`ifdef LEMMINGS_NUKE_EN
                if (nuke) begin
                    state_d = ST_NUKE;
                end else if (spawn && last_spawn) begin
                    state_d = ST_DRAIN;
                end
`else
                if (spawn && last_spawn) begin
                    state_d = ST_DRAIN;
                end
`endif
            end
            ST_DRAIN: begin
`ifdef LEMMINGS_NUKE_EN
                if (nuke) begin
                    state_d = ST_NUKE;
                end else if (drained) begin
                    state_d = ST_DONE;
                end
`else
                if (drained) begin
                    state_d = ST_DONE;
                end
`endif
            end
`ifdef LEMMINGS_NUKE_EN
            ST_NUKE: begin
                if (drained) begin
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next values: config latch, spawn timer, tallies, win/err.
    // -----------------------------------------------------------------------
    always_comb begin
        timer_d    = timer_q;
        interval_d = interval_q;
        total_d    = total_q;
        target_d   = target_q;
        spawned_d  = spawned_q;
        alive_d    = alive_q;
        saved_d    = saved_q;
        lost_d     = lost_q;
        win_d      = win_q;
        err_d      = err_q;

        if (!in_level) begin
            if (start) begin
                // An accepted start wins over a stray event in the same cycle.
                interval_d = cfg_interval;
                total_d    = cfg_total;
                target_d   = cfg_target;
                timer_d    = cfg_interval;
                spawned_d  = '0;
                alive_d    = '0;
                saved_d    = '0;
                lost_d     = '0;
                win_d      = 1'b0;
                err_d      = 1'b0;
            end else if (lem_exit || lem_die) begin
                err_d = 1'b1;
            end
        end else begin
            // Timer counts only while releasing and not paused; reload on release.
            if ((state_q == ST_SPAWNING) && !pause) begin
                timer_d = (timer_q == '0) ? interval_q : (timer_q - INT_W'(1));
            end
            if (spawn) begin
                spawned_d = spawned_q + CNT_W'(1);
            end
            alive_d = after_exit - CNT_W'(die_ok);
            saved_d = saved_q + CNT_W'(exit_ok);
            lost_d  = lost_q + CNT_W'(die_ok);
            if ((lem_exit && !exit_ok) || (lem_die && !die_ok)) begin
                err_d = 1'b1;
            end
            // DONE is only entered with no events, so saved_q is final here.
            if (state_d == ST_DONE) begin
                win_d = (saved_q >= target_q);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs.
    // -----------------------------------------------------------------------
    always_comb begin
        busy     = in_level;
        done     = (state_q == ST_DONE);
        spawn_id = spawned_q;
        alive    = alive_q;
        saved    = saved_q;
        lost     = lost_q;
        win      = win_q;
        err      = err_q;
`ifdef LEMMINGS_NUKE_EN
        nuke_all = (state_q == ST_NUKE);
`endif
    end

endmodule

// File: tb/tb_lemmings_level_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lemmings_level_sequencer
//
// Directed bench for lemmings_level_sequencer.  Cycle numbering inside each
// scenario: cycle 1 is the cycle that begins at the start edge, cycle n
// begins n-1 edges later.  Inputs are driven and outputs sampled 1 time unit
// after the rising edge that opens each cycle.
// ---------------------------------------------------------------------------
module tb_lemmings_level_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       pause;
    logic [7:0] cfg_total;
    logic [7:0] cfg_target;
    logic [7:0] cfg_interval;
    logic       lem_exit;
    logic       lem_die;
`ifdef LEMMINGS_NUKE_EN
    logic       nuke;
    logic       nuke_all;
`endif
    logic       spawn;
    logic [7:0] spawn_id;
    logic       busy;
    logic [7:0] alive;
    logic [7:0] saved;
    logic [7:0] lost;
    logic       done;
    logic       win;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    lemmings_level_sequencer #(.CNT_W(8), .INT_W(8)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .pause        (pause),
        .cfg_total    (cfg_total),
        .cfg_target   (cfg_target),
        .cfg_interval (cfg_interval),
        .lem_exit     (lem_exit),
        .lem_die      (lem_die),
`ifdef LEMMINGS_NUKE_EN
        .nuke         (nuke),
        .nuke_all     (nuke_all),
`endif
        .spawn        (spawn),
        .spawn_id     (spawn_id),
        .busy         (busy),
        .alive        (alive),
        .saved        (saved),
        .lost         (lost),
        .done         (done),
        .win          (win),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start with the given config for one edge; returns in cycle 1.
    task automatic do_start(input logic [7:0] t, input logic [7:0] tg, input logic [7:0] iv);
        cfg_total    = t;
        cfg_target   = tg;
        cfg_interval = iv;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({spawn, busy, done, win, err} !== 5'b00000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {spawn, busy, done, win, err});
        end
        n_checks++;
        if ({spawn_id, alive, saved, lost} !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_counts: got %h expected 00000000", {spawn_id, alive, saved, lost});
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset_midlevel();
        logic exp_spawn;
        do_start(8'd5, 8'd1, 8'd2);
        for (int c = 1; c <= 6; c++) begin
            exp_spawn = (c == 3) || (c == 6);
            n_checks++;
            if (spawn !== exp_spawn) begin
                n_fail++;
                $display("[TB] FAIL midreset_spawn c%0d: got %b expected %b", c, spawn, exp_spawn);
            end
            tick();
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        n_checks++;
        if ({spawn, busy, done, win, err} !== 5'b00000) begin
            n_fail++;
            $display("[TB] FAIL midreset_flags: got %b expected 00000", {spawn, busy, done, win, err});
        end
        n_checks++;
        if ({spawn_id, alive, saved, lost} !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL midreset_counts: got %h expected 00000000", {spawn_id, alive, saved, lost});
        end
        for (int c = 8; c <= 12; c++) begin
            n_checks++;
            if ({spawn, busy} !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL midreset_idle c%0d: got %b expected 00", c, {spawn, busy});
            end
            tick();
        end
    endtask

    task automatic test_basic_level();
        logic       exp_spawn;
        logic [7:0] exp_id;
        exp_id = 8'd0;
        do_start(8'd3, 8'd2, 8'd2);
        for (int c = 1; c <= 15; c++) begin
            lem_exit  = (c == 8) || (c == 11) || (c == 14);
            exp_spawn = (c == 3) || (c == 6) || (c == 9);
            n_checks++;
            if (spawn !== exp_spawn) begin
                n_fail++;
                $display("[TB] FAIL basic_spawn c%0d: got %b expected %b", c, spawn, exp_spawn);
            end
            if (exp_spawn) begin
                n_checks++;
                if (spawn_id !== exp_id) begin
                    n_fail++;
                    $display("[TB] FAIL basic_spawn_id c%0d: got %0d expected %0d", c, spawn_id, exp_id);
                end
                exp_id = exp_id + 8'd1;
            end
            if (c == 10) begin
                n_checks++;
                if ({busy, alive} !== {1'b1, 8'd2}) begin
                    n_fail++;
                    $display("[TB] FAIL basic_alive_mid: got busy=%b alive=%0d expected busy=1 alive=2", busy, alive);
                end
            end
            tick();
        end
        lem_exit = 1'b0;
        n_checks++;
        if ({done, busy, win, err} !== 4'b1010) begin
            n_fail++;
            $display("[TB] FAIL basic_done_flags: got %b expected 1010", {done, busy, win, err});
        end
        n_checks++;
        if ({alive, saved, lost} !== {8'd0, 8'd3, 8'd0}) begin
            n_fail++;
            $display("[TB] FAIL basic_tallies: got alive=%0d saved=%0d lost=%0d expected 0/3/0", alive, saved, lost);
        end
    endtask

    task automatic test_pause();
        logic exp_spawn;
        do_start(8'd2, 8'd1, 8'd1);
        for (int c = 1; c <= 11; c++) begin
            pause     = (c >= 3) && (c <= 6);
            lem_exit  = (c == 4) || (c == 10);
            exp_spawn = (c == 2) || (c == 8);
            #1;
            n_checks++;
            if (spawn !== exp_spawn) begin
                n_fail++;
                $display("[TB] FAIL pause_spawn c%0d: got %b expected %b", c, spawn, exp_spawn);
            end
            if (c == 5) begin
                n_checks++;
                if (saved !== 8'd1) begin
                    n_fail++;
                    $display("[TB] FAIL pause_saved: got %0d expected 1", saved);
                end
            end
            tick();
        end
        pause    = 1'b0;
        lem_exit = 1'b0;
        n_checks++;
        if ({done, busy, win, err} !== 4'b1010 || saved !== 8'd2) begin
            n_fail++;
            $display("[TB] FAIL pause_done: got flags=%b saved=%0d expected flags=1010 saved=2", {done, busy, win, err}, saved);
        end
    endtask

    task automatic test_simultaneous();
        do_start(8'd3, 8'd0, 8'd0);
        for (int c = 1; c <= 3; c++) begin
            lem_exit = (c == 3);
            lem_die  = (c == 3);
            n_checks++;
            if ({spawn, spawn_id} !== {1'b1, 8'(c - 1)}) begin
                n_fail++;
                $display("[TB] FAIL b2b_spawn c%0d: got spawn=%b id=%0d expected spawn=1 id=%0d", c, spawn, spawn_id, c - 1);
            end
            tick();
        end
        lem_exit = 1'b0;
        lem_die  = 1'b0;
        n_checks++;
        if ({alive, saved, lost} !== {8'd1, 8'd1, 8'd1} || err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL simul_tallies: got alive=%0d saved=%0d lost=%0d err=%b expected 1/1/1 err=0", alive, saved, lost, err);
        end
        tick();
        lem_die = 1'b1;
        tick();
        lem_die = 1'b0;
        tick();
        n_checks++;
        if ({done, busy, win, err} !== 4'b1010 || {alive, saved, lost} !== {8'd0, 8'd1, 8'd2}) begin
            n_fail++;
            $display("[TB] FAIL simul_done: got flags=%b alive=%0d saved=%0d lost=%0d expected 1010 0/1/2", {done, busy, win, err}, alive, saved, lost);
        end
        // A stray exit after the level is over is flagged, not counted.
        lem_exit = 1'b1;
        tick();
        lem_exit = 1'b0;
        n_checks++;
        if ({done, err} !== 2'b11 || saved !== 8'd1) begin
            n_fail++;
            $display("[TB] FAIL done_event_err: got done=%b err=%b saved=%0d expected 1 1 1", done, err, saved);
        end
    endtask

    task automatic test_underflow();
        do_start(8'd0, 8'd1, 8'd5);
        n_checks++;
        if ({busy, err, done} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL empty_level_start: got busy=%b err=%b done=%b expected 1 0 0", busy, err, done);
        end
        lem_die = 1'b1;
        tick();
        lem_die = 1'b0;
        n_checks++;
        if ({busy, err} !== 2'b11 || lost !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL underflow_err: got busy=%b err=%b lost=%0d expected 1 1 0", busy, err, lost);
        end
        tick();
        n_checks++;
        if ({done, busy, win, err} !== 4'b1001 || lost !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL underflow_done: got flags=%b lost=%0d expected 1001 0", {done, busy, win, err}, lost);
        end
        do_start(8'd1, 8'd0, 8'd0);
        n_checks++;
        if ({spawn, busy, err, win, done} !== 5'b11000) begin
            n_fail++;
            $display("[TB] FAIL restart_clears: got %b expected 11000", {spawn, busy, err, win, done});
        end
        tick();
        lem_exit = 1'b1;
        tick();
        lem_exit = 1'b0;
        tick();
        n_checks++;
        if ({done, busy, win, err} !== 4'b1010 || saved !== 8'd1) begin
            n_fail++;
            $display("[TB] FAIL single_done: got flags=%b saved=%0d expected 1010 1", {done, busy, win, err}, saved);
        end
    endtask

`ifdef LEMMINGS_NUKE_EN
    task automatic test_nuke();
        logic exp_spawn;
        do_start(8'd10, 8'd1, 8'd1);
        for (int c = 1; c <= 7; c++) begin
            nuke      = (c == 7);
            exp_spawn = (c == 2) || (c == 4) || (c == 6);
            n_checks++;
            if (spawn !== exp_spawn) begin
                n_fail++;
                $display("[TB] FAIL nuke_pre_spawn c%0d: got %b expected %b", c, spawn, exp_spawn);
            end
            tick();
        end
        nuke = 1'b0;
        for (int c = 8; c <= 11; c++) begin
            lem_die = (c <= 10);
            n_checks++;
            if ({nuke_all, spawn, done} !== 3'b100) begin
                n_fail++;
                $display("[TB] FAIL nuke_active c%0d: got %b expected 100", c, {nuke_all, spawn, done});
            end
            tick();
        end
        lem_die = 1'b0;
        n_checks++;
        if ({done, nuke_all, win, busy} !== 4'b1000 || lost !== 8'd3) begin
            n_fail++;
            $display("[TB] FAIL nuke_done: got flags=%b lost=%0d expected 1000 3", {done, nuke_all, win, busy}, lost);
        end
    endtask
`endif

    initial begin
        resetn       = 1'b0;
        start        = 1'b0;
        pause        = 1'b0;
        cfg_total    = 8'd0;
        cfg_target   = 8'd0;
        cfg_interval = 8'd0;
        lem_exit     = 1'b0;
        lem_die      = 1'b0;
`ifdef LEMMINGS_NUKE_EN
        nuke         = 1'b0;
`endif
        test_reset();
        test_reset_midlevel();
        test_basic_level();
        test_pause();
        test_simultaneous();
        test_underflow();
`ifdef LEMMINGS_NUKE_EN
        test_nuke();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lemmings_level_sequencer.md
Name: lemmings_level_sequencer

Overview:
Level-level controller for the lemming walker FSMs. Releases lemmings from the hatch at a programmed interval up to a programmed total, and tracks alive/saved/lost counts from per-lemming exit/death pulses. Declares the level done and won/lost once the hatch is empty and no lemming remains alive. Sits above the per-lemming walkers: its spawn pulse resets/enables the next walker, and walker exit/death events feed back into it.

Parameters:
CNT_W, 8, width of total/target/alive/saved/lost/spawn_id counters
INT_W, 8, width of the spawn-interval register and down-timer

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  synchronous active-low reset
start  input  1  start level; sampled only in IDLE or DONE
pause  input  1  freezes the spawn timer only
cfg_total  input  CNT_W  lemmings to release, latched on start
cfg_target  input  CNT_W  saved count needed to win, latched on start
cfg_interval  input  INT_W  idle cycles between spawns, latched on start
lem_exit  input  1  one lemming reached the exit this cycle
lem_die  input  1  one (different) lemming died this cycle
spawn  output  1  one-cycle release pulse
spawn_id  output  CNT_W  0-based index of lemming released, valid with spawn
busy  output  1  high in SPAWNING, DRAIN (and NUKE)
alive  output  CNT_W  lemmings currently in play
saved  output  CNT_W  lemmings saved this level
lost  output  CNT_W  lemmings lost this level
done  output  1  high in DONE
win  output  1  registered saved>=target, valid while done
err  output  1  sticky event-accounting error, cleared on accepted start

Behaviour:
- Reset (resetn=0 at edge, any state incl. mid-level): state=IDLE; timer, spawned, alive, saved, lost=0; spawn=0, spawn_id=0, busy=0, done=0, win=0, err=0.
- States: IDLE, SPAWNING, DRAIN, DONE (+NUKE with option).
- IDLE/DONE + start: latch cfg_*, clear spawned/alive/saved/lost/err/win, timer<=cfg_interval; go SPAWNING if cfg_total!=0, else DRAIN. start while busy ignored.
- spawn is combinational: state==SPAWNING && timer==0 && !pause. spawn_id = spawned (pre-increment).
- SPAWNING, unpaused: timer==0 -> spawn, timer<=cfg_interval, spawned++; else timer--. First spawn occurs cfg_interval+1 cycles after the start edge; interval 0 spawns every cycle.
- Spawn making spawned==cfg_total -> DRAIN next cycle. pause holds timer and spawn low; events still counted.
- Counter update each cycle in SPAWNING/DRAIN: alive <= alive + spawn - lem_exit - lem_die; saved += lem_exit; lost += lem_die. Simultaneous spawn+exit+die all apply.
- Removal exceeding alive+spawn: exit is honoured before die; excess event ignored (not counted), err<=1.
- lem_exit/lem_die in IDLE or DONE: ignored, err<=1.
- DRAIN: when alive==0 at the start of the cycle and no events -> DONE; win<=(saved>=cfg_target) at that edge.
- DONE: done=1 held until accepted start or reset; all counters hold.
- cfg_target>cfg_total is legal; win is then always 0.

Optional Feature:
LEMMINGS_NUKE_EN
- Defined: adds input nuke (1 bit) and output nuke_all (1 bit). nuke in SPAWNING/DRAIN -> state NUKE next cycle: spawning stops immediately, nuke_all=1, deaths/exits counted as usual; alive==0 -> DONE, win computed normally. nuke in IDLE/DONE ignored.
- Undefined: no nuke/nuke_all ports, no NUKE state; behaviour otherwise identical.

Test Plan:
- Reset mid-level: start total=5,interval=2, deassert resetn after 2 spawns -> next cycle IDLE, all outputs 0, no further spawn.
- Basic level: total=3,target=2,interval=2, exits 5 cycles after each spawn -> spawns at +3,+6,+9 cycles after start, ids 0,1,2; done with saved=3, lost=0, win=1.
- Pause: total=2,interval=1, pause 4 cycles after first spawn -> second spawn delayed exactly 4 cycles; exit during pause still increments saved.
- Simultaneous events: alive=2, spawn+lem_exit+lem_die same cycle -> alive=1, saved=1, lost=1, err=0.
- Underflow: alive=0 in DRAIN, lem_die=1 -> lost unchanged, err=1, state reaches DONE; err cleared by next start.
- Nuke (LEMMINGS_NUKE_EN): total=10, nuke after 3 spawns -> no further spawn, nuke_all=1 until 3 deaths, then done=1, lost=3, win=0 (target=1).
